fft_agu_ctrl: RTL and testbench
===============================

FFT_AGU_CTRL -- requirements
Module: fft_agu_ctrl

Interface
REQ-001 SHALL have parameter BFLY_LAT, default 3, cycles from butterfly operand read address to result write address (1..7).
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle request to begin a load+transform frame.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1, the sample-load handshake; a sample is accepted when both are high.
REQ-006 SHALL have ports LoadEnable out 1, LoadDataWrite out 1, LoadDataAddr out 5, the memory load controls.
REQ-007 SHALL have ports ReadGAddr, ReadHAddr, WriteGAddr, WriteHAddr  out  5 each, the butterfly operand and result addresses.
REQ-008 SHALL have port TwiddleAddr  out  4  twiddle ROM index for the current read.
REQ-009 SHALL have ports RWAddrEN, BankReadSelect, Bank0WriteEN, Bank1WriteEN  out  1 each, the ping-pong bank controls.
REQ-010 SHALL have ports busy out 1, done out 1 (one-cycle pulse), stage out 3 (current stage 0..4).

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> READ -> DRAIN -> (READ | FINISH) -> IDLE; N=32, 5 stages, 16 butterflies/stage.
REQ-012 IDLE: in_ready=0, all enables 0; start=1 -> LOAD next cycle; busy=0 only in IDLE.
REQ-013 LOAD: LoadEnable=1, in_ready=1, LoadDataWrite=in_valid, 5-bit load counter increments per accepted sample; in_valid low stalls with no address advance.
REQ-014 LOAD exits to READ with stage=0 on the cycle after the 32nd accepted sample (counter wraps 31->0).
REQ-015 READ: butterfly counter b (0..15) advances every cycle; for stage s: ReadGAddr = ((b>>s)<<(s+1)) | (b & (2^s-1)); ReadHAddr = ReadGAddr + 2^s; TwiddleAddr = (b & (2^s-1)) << (4-s).
REQ-016 WriteGAddr/WriteHAddr SHALL equal ReadGAddr/ReadHAddr delayed exactly BFLY_LAT cycles, via a shift register of depth BFLY_LAT.
REQ-017 The write-enable for the destination bank SHALL be high exactly on the 16 cycles where a delayed valid write address is present, and 0 otherwise.
REQ-018 Bank ping-pong: BankReadSelect = s[0]; RWAddrEN = ~s[0]; even stages write bank 1 (Bank1WriteEN), odd stages write bank 0 (Bank0WriteEN); LOAD writes bank 0.
REQ-019 After b=15, READ -> DRAIN; DRAIN lasts BFLY_LAT cycles, so that no stage reads before the previous stage's last write.
REQ-020 DRAIN end: stage<4 -> stage+1, b=0, READ; stage=4 -> FINISH.
REQ-021 FINISH: done=1 for exactly one cycle, BankReadSelect held at 1 (result in bank 1), then IDLE.
REQ-022 Transform latency from the first READ cycle to done SHALL be 5*(16+BFLY_LAT) cycles (95 at default).
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-024 Read and write bank SHALL never be the same bank in any cycle; Bank0WriteEN and Bank1WriteEN SHALL never both be 1.

Reset
REQ-025 reset=1 SHALL force IDLE asynchronously, with all counters, stage and delay line = 0.
REQ-026 During reset and afterwards until start: every output = 0, including all addresses, done, busy and in_ready.
REQ-027 Reset mid-LOAD or mid-transform SHALL abort the frame; no write-enable may be asserted on the cycle after reset deasserts.

Configuration
REQ-028 Macro FFT_BITREV_LOAD_EN defined: LoadDataAddr = bit-reverse of the load counter (sample k written to address rev5(k)).
REQ-029 FFT_BITREV_LOAD_EN undefined: LoadDataAddr = load counter (natural order); the upstream source supplies samples in bit-reversed order.

Verification
REQ-030 reset, start, 32 back-to-back in_valid -> LoadDataAddr sequence 0,16,8,24,4,... (macro on) or 0,1,2,... (macro off); READ entered the cycle after the 32nd sample.
REQ-031 in_valid toggled 1,0,1,0 during LOAD -> address advances only on accepted cycles; LOAD lasts 64 cycles.
REQ-032 stage 2, b=5 -> ReadGAddr=9, ReadHAddr=13, TwiddleAddr=4; WriteGAddr=9 appears BFLY_LAT cycles later with Bank1WriteEN=1.
REQ-033 full frame at BFLY_LAT=3 -> done pulses exactly 95 cycles after the first READ cycle; 80 write-enable cycles total, alternating bank 1/0 per stage.
REQ-034 start pulsed mid-transform -> no effect; reset asserted at stage 3 -> all outputs 0 immediately, then IDLE until the next start.

Source files
------------

// File: rtl/fft_agu_ctrl.sv
// Address generation and bank control for a 32-point radix-2 FFT: sample load, 5 butterfly stages, ping-pong banks.
// Optional macro FFT_BITREV_LOAD_EN: bit-reverse the load address instead of writing in natural order.
module fft_agu_ctrl #(
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       LoadEnable,
  output logic       LoadDataWrite,
  output logic [4:0] LoadDataAddr,
  output logic [4:0] ReadGAddr,
  output logic [4:0] ReadHAddr,
  output logic [4:0] WriteGAddr,
  output logic [4:0] WriteHAddr,
  output logic [3:0] TwiddleAddr,
  output logic       RWAddrEN,
  output logic       BankReadSelect,
  output logic       Bank0WriteEN,
  output logic       Bank1WriteEN,
  output logic       busy,
  output logic       done,
  output logic [2:0] stage
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, FINISH} stateT;

  stateT      state, nextState;
  logic [4:0] loadCnt;
  logic [3:0] bCnt;
  logic [2:0] drainCnt;
  logic [2:0] stageReg;
  logic       drainLast;

  logic [4:0] bExt, lowMask, rdG, rdH, loadAddr;
  logic [3:0] twid;

  logic [4:0] gPipe [BFLY_LAT];
  logic [4:0] hPipe [BFLY_LAT];
  logic       vPipe [BFLY_LAT];
  logic       wrValid;

  assign drainLast = (drainCnt == 3'(BFLY_LAT - 1));

  // Butterfly pair: insert a zero at bit position `stage` of b; partner differs only in that bit.
  always_comb begin
    bExt    = {1'b0, bCnt};
    lowMask = (5'd1 << stageReg) - 5'd1;
    rdG     = ((bExt >> stageReg) << (stageReg + 3'd1)) | (bExt & lowMask);
    rdH     = rdG + (5'd1 << stageReg);
    twid    = (bCnt & lowMask[3:0]) << (3'd4 - stageReg);
  end

`ifdef FFT_BITREV_LOAD_EN
  assign loadAddr = {loadCnt[0], loadCnt[1], loadCnt[2], loadCnt[3], loadCnt[4]};
`else
  assign loadAddr = loadCnt;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState      = state;
    in_ready       = 1'b0;
    LoadEnable     = 1'b0;
    LoadDataWrite  = 1'b0;
    LoadDataAddr   = '0;
    ReadGAddr      = '0;
    ReadHAddr      = '0;
    TwiddleAddr    = '0;
    RWAddrEN       = 1'b0;
    BankReadSelect = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nextState = LOAD;
      end
      LOAD: begin
        in_ready      = 1'b1;
        LoadEnable    = 1'b1;
        LoadDataWrite = in_valid;
        LoadDataAddr  = loadAddr;
        if (in_valid && loadCnt == 5'd31) nextState = READ;
      end
      READ: begin
        ReadGAddr      = rdG;
        ReadHAddr      = rdH;
        TwiddleAddr    = twid;
        RWAddrEN       = ~stageReg[0];
        BankReadSelect = stageReg[0];
        if (bCnt == 4'd15) nextState = DRAIN;
      end
      DRAIN: begin
        RWAddrEN       = ~stageReg[0];
        BankReadSelect = stageReg[0];
        if (drainLast) nextState = (stageReg == 3'd4) ? FINISH : READ;
      end
      FINISH: begin
        done           = 1'b1;
        BankReadSelect = 1'b1;
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loadCnt  <= '0;
      bCnt     <= '0;
      drainCnt <= '0;
      stageReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          loadCnt  <= '0;
          bCnt     <= '0;
          drainCnt <= '0;
          stageReg <= '0;
        end
        LOAD: if (in_valid) loadCnt <= loadCnt + 5'd1;
        READ: begin
          bCnt     <= bCnt + 4'd1;
          drainCnt <= '0;
        end
        DRAIN: begin
          if (drainLast) begin
            drainCnt <= '0;
            if (stageReg != 3'd4) stageReg <= stageReg + 3'd1;
          end else begin
            drainCnt <= drainCnt + 3'd1;
          end
        end
        FINISH:  stageReg <= '0;
        default: stageReg <= '0;
      endcase
    end
  end

  // Read addresses ride a BFLY_LAT-deep pipe so writes land when the butterfly result emerges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BFLY_LAT; i++) begin
        gPipe[i] <= '0;
        hPipe[i] <= '0;
        vPipe[i] <= 1'b0;
      end
    end else begin
      gPipe[0] <= ReadGAddr;
      hPipe[0] <= ReadHAddr;
      vPipe[0] <= (state == READ);
      for (int unsigned i = 1; i < BFLY_LAT; i++) begin
        gPipe[i] <= gPipe[i-1];
        hPipe[i] <= hPipe[i-1];
        vPipe[i] <= vPipe[i-1];
      end
    end
  end

  assign wrValid      = vPipe[BFLY_LAT-1];
  assign WriteGAddr   = gPipe[BFLY_LAT-1];
  assign WriteHAddr   = hPipe[BFLY_LAT-1];
  // A stage's last write completes inside its DRAIN, so the current stage parity picks the write bank.
  assign Bank1WriteEN = wrValid & ~stageReg[0];
  assign Bank0WriteEN = (wrValid & stageReg[0]) | LoadDataWrite;
  assign stage        = stageReg;

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Directed self-checking bench for fft_agu_ctrl at BFLY_LAT=3; honours FFT_BITREV_LOAD_EN when defined.
module tb_fft_agu_ctrl;

  localparam int unsigned LAT = 3;
  localparam int FRAME = 5 * (16 + LAT);

  logic       clock = 1'b0;
  logic       reset, start, in_valid;
  logic       in_ready, LoadEnable, LoadDataWrite;
  logic [4:0] LoadDataAddr, ReadGAddr, ReadHAddr, WriteGAddr, WriteHAddr;
  logic [3:0] TwiddleAddr;
  logic       RWAddrEN, BankReadSelect, Bank0WriteEN, Bank1WriteEN, busy, done;
  logic [2:0] stage;
  logic [40:0] allOuts;

  int nVec  = 0;
  int nFail = 0;

  always #5 clock = ~clock;

  fft_agu_ctrl #(.BFLY_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .LoadEnable(LoadEnable), .LoadDataWrite(LoadDataWrite), .LoadDataAddr(LoadDataAddr),
    .ReadGAddr(ReadGAddr), .ReadHAddr(ReadHAddr),
    .WriteGAddr(WriteGAddr), .WriteHAddr(WriteHAddr),
    .TwiddleAddr(TwiddleAddr), .RWAddrEN(RWAddrEN), .BankReadSelect(BankReadSelect),
    .Bank0WriteEN(Bank0WriteEN), .Bank1WriteEN(Bank1WriteEN),
    .busy(busy), .done(done), .stage(stage)
  );

  assign allOuts = {in_ready, LoadEnable, LoadDataWrite, LoadDataAddr, ReadGAddr, ReadHAddr,
                    WriteGAddr, WriteHAddr, TwiddleAddr, RWAddrEN, BankReadSelect,
                    Bank0WriteEN, Bank1WriteEN, busy, done, stage};

  function automatic logic [4:0] expLoadAddr(input int k);
    logic [4:0] c;
    c = k[4:0];
`ifdef FFT_BITREV_LOAD_EN
    return {c[0], c[1], c[2], c[3], c[4]};
`else
    return c;
`endif
  endfunction

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b1;
    #3;
    nVec++;
    if (allOuts !== '0) begin nFail++; $display("FAIL reset_hold: outs=%h want 0", allOuts); end
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    nVec++;
    if (allOuts !== '0) begin nFail++; $display("FAIL reset_start: outs=%h want 0", allOuts); end
    start = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      nVec++;
      if (allOuts !== '0) begin nFail++; $display("FAIL post_reset_idle%0d: outs=%h want 0", i, allOuts); end
    end
  endtask

  task automatic test_load();
    pulseStart();
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      #1;
      nVec++;
      if ({in_ready, LoadEnable, LoadDataWrite, Bank0WriteEN, Bank1WriteEN, busy, LoadDataAddr}
          !== {6'b111101, expLoadAddr(k)}) begin
        nFail++;
        $display("FAIL load_k%0d: rdy/en/wr/b0/b1/busy/addr=%b/%b/%b/%b/%b/%b/%0d want 1/1/1/1/0/1/%0d",
                 k, in_ready, LoadEnable, LoadDataWrite, Bank0WriteEN, Bank1WriteEN, busy,
                 LoadDataAddr, expLoadAddr(k));
      end
    end
  endtask

  task automatic test_transform();
    int doneT = -1;
    int w0 = 0, w1 = 0, clash = 0;
    logic doneBrs = 1'b0;
    for (int t = 0; t < FRAME + 20 && doneT < 0; t++) begin
      @(negedge clock);
      in_valid = 1'b0;
      start = (t == 30);
      #1;
      if (Bank0WriteEN) w0++;
      if (Bank1WriteEN) w1++;
      if ((Bank0WriteEN && Bank1WriteEN) || (Bank1WriteEN && BankReadSelect) ||
          (Bank0WriteEN && !BankReadSelect)) clash++;
      if (done) begin doneT = t; doneBrs = BankReadSelect; end
      case (t)
        0: begin
          nVec++;
          if ({in_ready, RWAddrEN, BankReadSelect, stage, ReadGAddr, ReadHAddr, TwiddleAddr}
              !== {1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd1, 4'd0}) begin
            nFail++; $display("FAIL read_entry: rdy=%b rwen=%b brs=%b st=%0d g=%0d h=%0d tw=%0d want 0 1 0 0 0 1 0",
                              in_ready, RWAddrEN, BankReadSelect, stage, ReadGAddr, ReadHAddr, TwiddleAddr);
          end
        end
        2: begin
          nVec++;
          if ({Bank0WriteEN, Bank1WriteEN} !== 2'b00) begin
            nFail++; $display("FAIL early_write: b0=%b b1=%b want 0 0", Bank0WriteEN, Bank1WriteEN);
          end
        end
        3: begin
          nVec++;
          if ({ReadGAddr, ReadHAddr, TwiddleAddr, Bank1WriteEN, WriteGAddr, WriteHAddr}
              !== {5'd6, 5'd7, 4'd0, 1'b1, 5'd0, 5'd1}) begin
            nFail++; $display("FAIL s0b3: g=%0d h=%0d tw=%0d b1=%b wg=%0d wh=%0d want 6 7 0 1 0 1",
                              ReadGAddr, ReadHAddr, TwiddleAddr, Bank1WriteEN, WriteGAddr, WriteHAddr);
          end
        end
        18: begin
          nVec++;
          if ({Bank1WriteEN, Bank0WriteEN, WriteGAddr, WriteHAddr} !== {1'b1, 1'b0, 5'd30, 5'd31}) begin
            nFail++; $display("FAIL s0_last_write: b1=%b b0=%b wg=%0d wh=%0d want 1 0 30 31",
                              Bank1WriteEN, Bank0WriteEN, WriteGAddr, WriteHAddr);
          end
        end
        19: begin
          nVec++;
          if ({stage, RWAddrEN, BankReadSelect, Bank0WriteEN, Bank1WriteEN, ReadGAddr, ReadHAddr}
              !== {3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd2}) begin
            nFail++; $display("FAIL s1_entry: st=%0d rwen=%b brs=%b b0=%b b1=%b g=%0d h=%0d want 1 0 1 0 0 0 2",
                              stage, RWAddrEN, BankReadSelect, Bank0WriteEN, Bank1WriteEN, ReadGAddr, ReadHAddr);
          end
        end
        22: begin
          nVec++;
          if ({Bank0WriteEN, Bank1WriteEN, WriteGAddr, WriteHAddr} !== {1'b1, 1'b0, 5'd0, 5'd2}) begin
            nFail++; $display("FAIL s1_first_write: b0=%b b1=%b wg=%0d wh=%0d want 1 0 0 2",
                              Bank0WriteEN, Bank1WriteEN, WriteGAddr, WriteHAddr);
          end
        end
        24: begin
          nVec++;
          if ({ReadGAddr, ReadHAddr, TwiddleAddr} !== {5'd9, 5'd11, 4'd8}) begin
            nFail++; $display("FAIL s1b5: g=%0d h=%0d tw=%0d want 9 11 8", ReadGAddr, ReadHAddr, TwiddleAddr);
          end
        end
        43: begin
          nVec++;
          if ({stage, ReadGAddr, ReadHAddr, TwiddleAddr} !== {3'd2, 5'd9, 5'd13, 4'd4}) begin
            nFail++; $display("FAIL s2b5: st=%0d g=%0d h=%0d tw=%0d want 2 9 13 4",
                              stage, ReadGAddr, ReadHAddr, TwiddleAddr);
          end
        end
        46: begin
          nVec++;
          if ({Bank1WriteEN, Bank0WriteEN, WriteGAddr, WriteHAddr} !== {1'b1, 1'b0, 5'd9, 5'd13}) begin
            nFail++; $display("FAIL s2b5_write: b1=%b b0=%b wg=%0d wh=%0d want 1 0 9 13",
                              Bank1WriteEN, Bank0WriteEN, WriteGAddr, WriteHAddr);
          end
        end
        70: begin
          nVec++;
          if ({stage, ReadGAddr, ReadHAddr, TwiddleAddr} !== {3'd3, 5'd21, 5'd29, 4'd10}) begin
            nFail++; $display("FAIL s3b13: st=%0d g=%0d h=%0d tw=%0d want 3 21 29 10",
                              stage, ReadGAddr, ReadHAddr, TwiddleAddr);
          end
        end
        83: begin
          nVec++;
          if ({stage, ReadGAddr, ReadHAddr, TwiddleAddr} !== {3'd4, 5'd7, 5'd23, 4'd7}) begin
            nFail++; $display("FAIL s4b7: st=%0d g=%0d h=%0d tw=%0d want 4 7 23 7",
                              stage, ReadGAddr, ReadHAddr, TwiddleAddr);
          end
        end
        94: begin
          nVec++;
          if ({Bank1WriteEN, WriteGAddr, WriteHAddr, done} !== {1'b1, 5'd15, 5'd31, 1'b0}) begin
            nFail++; $display("FAIL s4_last_write: b1=%b wg=%0d wh=%0d done=%b want 1 15 31 0",
                              Bank1WriteEN, WriteGAddr, WriteHAddr, done);
          end
        end
        default: ;
      endcase
    end
    nVec++;
    if (doneT != FRAME) begin nFail++; $display("FAIL done_latency: got %0d want %0d", doneT, FRAME); end
    nVec++;
    if (doneBrs !== 1'b1) begin nFail++; $display("FAIL finish_bank: brs=%b want 1", doneBrs); end
    nVec++;
    if (w0 != 32 || w1 != 48) begin nFail++; $display("FAIL write_counts: b0=%0d b1=%0d want 32 48", w0, w1); end
    nVec++;
    if (clash != 0) begin nFail++; $display("FAIL bank_clash: %0d cycles want 0", clash); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      nVec++;
      if (allOuts !== '0) begin nFail++; $display("FAIL idle_after_done%0d: outs=%h want 0", i, allOuts); end
    end
  endtask

  task automatic test_stall();
    logic gotDone = 1'b0;
    pulseStart();
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      in_valid = i[0];
      #1;
      nVec++;
      if ({in_ready, LoadDataWrite, LoadDataAddr} !== {1'b1, i[0], expLoadAddr(i / 2)}) begin
        nFail++; $display("FAIL stall_c%0d: rdy=%b wr=%b addr=%0d want 1 %b %0d",
                          i, in_ready, LoadDataWrite, LoadDataAddr, i[0], expLoadAddr(i / 2));
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    nVec++;
    if ({in_ready, RWAddrEN} !== 2'b01) begin
      nFail++; $display("FAIL stall_exit: rdy=%b rwen=%b want 0 1", in_ready, RWAddrEN);
    end
    for (int c = 0; c < 200 && !gotDone; c++) begin
      @(negedge clock); #1;
      if (done) gotDone = 1'b1;
    end
    nVec++;
    if (gotDone !== 1'b1) begin nFail++; $display("FAIL stall_frame_done: got %b want 1", gotDone); end
  endtask

  task automatic test_reset_midframe();
    pulseStart();
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
    end
    for (int t = 0; t <= 62; t++) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    #1;
    nVec++;
    if (stage !== 3'd3) begin nFail++; $display("FAIL pre_abort_stage: got %0d want 3", stage); end
    #2 reset = 1'b1;
    #1;
    nVec++;
    if (allOuts !== '0) begin nFail++; $display("FAIL abort_async: outs=%h want 0", allOuts); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      nVec++;
      if (allOuts !== '0) begin nFail++; $display("FAIL abort_idle%0d: outs=%h want 0", i, allOuts); end
      @(negedge clock);
    end
    pulseStart();
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    nVec++;
    if ({in_ready, LoadEnable, busy, LoadDataAddr} !== {3'b111, 5'd0}) begin
      nFail++; $display("FAIL restart_load: rdy=%b en=%b busy=%b addr=%0d want 1 1 1 0",
                        in_ready, LoadEnable, busy, LoadDataAddr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_transform();
    test_stall();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
